// File: rtl/hex_display_scan_pkg.sv
// rtl/hex_display_scan_pkg.sv - shared segment types, glyph constants and scan states
package hex_display_scan_pkg;

    // Segment vectors are ordered abcdefg with index 0 = segment a; values are active-low.
    typedef logic [0:6] seg_t;

    localparam seg_t SEG_OFF = 7'b1111111;

    localparam seg_t GLYPH_0 = 7'b0000001;
    localparam seg_t GLYPH_1 = 7'b1001111;
    localparam seg_t GLYPH_2 = 7'b0010010;
    localparam seg_t GLYPH_3 = 7'b0000110;
    localparam seg_t GLYPH_4 = 7'b1001100;
    localparam seg_t GLYPH_5 = 7'b0100100;
    localparam seg_t GLYPH_6 = 7'b0100000;
    localparam seg_t GLYPH_7 = 7'b0001101;
    localparam seg_t GLYPH_8 = 7'b0000000;
    localparam seg_t GLYPH_9 = 7'b0000100;
    localparam seg_t GLYPH_A = 7'b0001000;
    localparam seg_t GLYPH_B = 7'b1100000;
    localparam seg_t GLYPH_C = 7'b0110001;
    localparam seg_t GLYPH_D = 7'b1000010;
    localparam seg_t GLYPH_E = 7'b0110000;
    localparam seg_t GLYPH_F = 7'b0111000;

    typedef enum logic {
        ST_DEAD,
        ST_SHOW
    } scan_state_e;

endpackage

// File: rtl/hex_display_scan_if.sv
// rtl/hex_display_scan_if.sv - load handshake and display pin bundle
interface hex_display_scan_if
    import hex_display_scan_pkg::*;
#(
    parameter int DIGITS = 4
);
    logic                  Load;
    logic [4*DIGITS-1:0]   Value;
    logic [DIGITS-1:0]     BlankMask;
    logic                  LzsEn;
    logic                  Pending;
    seg_t                  DISPLAY;
    logic [DIGITS-1:0]     DigitEn;
    logic                  FrameTick;

    modport master (
        output Load, Value, BlankMask, LzsEn,
        input  Pending, DISPLAY, DigitEn, FrameTick
    );

    modport slave (
        input  Load, Value, BlankMask, LzsEn,
        output Pending, DISPLAY, DigitEn, FrameTick
    );
endinterface

// File: rtl/hex_display_scan_glyph.sv
// rtl/hex_display_scan_glyph.sv - nibble to active-low abcdefg glyph decoder
module hex7seg_glyph
    import hex_display_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);
    always_comb begin
        seg = GLYPH_F;
        case (nibble)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            default: seg = GLYPH_F;
        endcase
    end
endmodule

// File: rtl/hex_display_scan.sv
// rtl/hex_display_scan.sv - frame-synchronous multiplexed 7-segment scanner
module hex_display_scan
    import hex_display_scan_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int DIV            = 50000,
    parameter int DEAD           = 2,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic               Clock,
    input  logic               Resetn,
    hex_display_scan_if.slave  bus
);
    localparam int PW = $clog2(DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW = 4 * DIGITS;
    localparam seg_t              SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;
    localparam logic [DIGITS-1:0] DIG_IDLE = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam scan_state_e       ST_RESET = (DEAD > 0) ? ST_DEAD : ST_SHOW;

    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    scan_state_e       state_q, state_d;
    logic [VW-1:0]     pend_value_q, pend_value_d, shadow_value_q, shadow_value_d;
    logic [DIGITS-1:0] pend_blank_q, pend_blank_d, shadow_blank_q, shadow_blank_d;
    logic              pend_lzs_q, pend_lzs_d, shadow_lzs_q, shadow_lzs_d;
    logic              pending_q, pending_d;
    seg_t              seg_q, seg_d;
    logic [DIGITS-1:0] dig_q, dig_d;
    logic              ftick_q, ftick_d;

    logic              slot_end, tick;
    logic [3:0]        cur_nibble;
    logic              cur_blank, lzs_hit, zero_above, show;
    seg_t              glyph_seg, seg_raw;
    logic [DIGITS-1:0] dig_raw;

    always_comb begin
        slot_end = (presc_q == PW'(DIV - 1));
        tick     = slot_end && (idx_q == IW'(DIGITS - 1));
        presc_d  = slot_end ? '0 : presc_q + 1'b1;
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        // State register tracks the prescaler so it always describes the current slot phase.
        state_d = (int'(presc_d) < DEAD) ? ST_DEAD : ST_SHOW;

        pend_value_d   = pend_value_q;
        pend_blank_d   = pend_blank_q;
        pend_lzs_d     = pend_lzs_q;
        pending_d      = pending_q;
        shadow_value_d = shadow_value_q;
        shadow_blank_d = shadow_blank_q;
        shadow_lzs_d   = shadow_lzs_q;
        if (bus.Load) begin
            pend_value_d = bus.Value;
            pend_blank_d = bus.BlankMask;
            pend_lzs_d   = bus.LzsEn;
        end
        // A load coinciding with the frame boundary bypasses the pending stage.
        if (tick) begin
            shadow_value_d = bus.Load ? bus.Value     : pend_value_q;
            shadow_blank_d = bus.Load ? bus.BlankMask : pend_blank_q;
            shadow_lzs_d   = bus.Load ? bus.LzsEn     : pend_lzs_q;
            pending_d      = 1'b0;
        end else if (bus.Load) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        cur_nibble = 4'h0;
        cur_blank  = 1'b0;
        dig_raw    = '1;
        show       = (state_q == ST_SHOW);
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nibble = shadow_value_q[i*4 +: 4];
                cur_blank  = shadow_blank_q[i];
            end
            dig_raw[i] = !(show && (idx_q == IW'(i)));
        end
        // Walk down from the top digit; zero_above covers nibbles i..DIGITS-1 at step i.
        lzs_hit    = 1'b0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (shadow_value_q[i*4 +: 4] != 4'h0) zero_above = 1'b0;
            if (shadow_lzs_q && zero_above && (idx_q == IW'(i))) lzs_hit = 1'b1;
        end
        seg_raw = (show && !cur_blank && !lzs_hit) ? glyph_seg : SEG_OFF;
        seg_d   = (SEG_ACTIVE_LOW != 0) ? seg_raw : ~seg_raw;
        dig_d   = (SEG_ACTIVE_LOW != 0) ? dig_raw : ~dig_raw;
        ftick_d = tick;
    end

    hex7seg_glyph u_glyph (
        .nibble (cur_nibble),
        .seg    (glyph_seg)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            presc_q        <= '0;
            idx_q          <= '0;
            state_q        <= ST_RESET;
            pend_value_q   <= '0;
            pend_blank_q   <= '0;
            pend_lzs_q     <= 1'b0;
            pending_q      <= 1'b0;
            shadow_value_q <= '0;
            shadow_blank_q <= '0;
            shadow_lzs_q   <= 1'b0;
            seg_q          <= SEG_IDLE;
            dig_q          <= DIG_IDLE;
            ftick_q        <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            idx_q          <= idx_d;
            state_q        <= state_d;
            pend_value_q   <= pend_value_d;
            pend_blank_q   <= pend_blank_d;
            pend_lzs_q     <= pend_lzs_d;
            pending_q      <= pending_d;
            shadow_value_q <= shadow_value_d;
            shadow_blank_q <= shadow_blank_d;
            shadow_lzs_q   <= shadow_lzs_d;
            seg_q          <= seg_d;
            dig_q          <= dig_d;
            ftick_q        <= ftick_d;
        end
    end

    assign bus.Pending   = pending_q;
    assign bus.DISPLAY   = seg_q;
    assign bus.DigitEn   = dig_q;
    assign bus.FrameTick = ftick_q;
endmodule

// File: tb/tb_hex_display_scan.sv
// tb/tb_hex_display_scan.sv - scoreboard bench with a cycle-count reference model
module tb_hex_display_scan;
    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int DEAD   = 2;
    localparam int FRAME  = DIGITS * DIV;

    localparam logic [0:6] GLYPH_REF [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct {
        int         t;
        logic [0:6] seg;
        logic [3:0] dig;
        logic       ftick;
        logic       pending;
    } exp_t;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;
    always #5 Clock = ~Clock;

    hex_display_scan_if #(.DIGITS(DIGITS)) bus ();

    hex_display_scan #(
        .DIGITS(DIGITS), .DIV(DIV), .DEAD(DEAD), .SEG_ACTIVE_LOW(1)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    int          model_t;
    logic [15:0] sh_v, pd_v;
    logic [3:0]  sh_m, pd_m;
    logic        sh_l, pd_l, pend;

    task automatic chk(input string name, input int t, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0d got=%0h want=%0h", name, t, got, want);
        end
    endtask

    // Expected pins for the slot position t clocks after reset release.
    function automatic exp_t predict(input int t);
        exp_t e;
        int phase;
        int d;
        logic [15:0] above;
        phase     = t % DIV;
        d         = (t / DIV) % DIGITS;
        e.t       = t;
        e.ftick   = ((t % FRAME) == FRAME - 1);
        e.pending = 1'b0;
        if (phase < DEAD) begin
            e.seg = 7'b1111111;
            e.dig = 4'b1111;
        end else begin
            e.dig = ~(4'b0001 << d);
            above = sh_v >> (4 * d);
            if (sh_m[d] || (sh_l && d > 0 && above == 16'h0)) e.seg = 7'b1111111;
            else e.seg = GLYPH_REF[above[3:0]];
        end
        return e;
    endfunction

    initial begin : model
        exp_t e;
        logic frame_end;
        forever begin
            @(posedge Clock);
            if (!Resetn) begin
                model_t = 0;
                sh_v = '0; sh_m = '0; sh_l = 1'b0;
                pd_v = '0; pd_m = '0; pd_l = 1'b0;
                pend = 1'b0;
            end else begin
                e = predict(model_t);
                frame_end = ((model_t % FRAME) == FRAME - 1);
                if (frame_end) begin
                    if (bus.Load) begin
                        sh_v = bus.Value; sh_m = bus.BlankMask; sh_l = bus.LzsEn;
                    end else begin
                        sh_v = pd_v; sh_m = pd_m; sh_l = pd_l;
                    end
                    pend = 1'b0;
                end else if (bus.Load) begin
                    pend = 1'b1;
                end
                if (bus.Load) begin
                    pd_v = bus.Value; pd_m = bus.BlankMask; pd_l = bus.LzsEn;
                end
                e.pending = pend;
                sb.push_back(e);
                model_t++;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("DISPLAY",   e.t, 32'(bus.DISPLAY), 32'(e.seg));
                chk("DigitEn",   e.t, 32'(bus.DigitEn), 32'(e.dig));
                chk("FrameTick", e.t, 32'(bus.FrameTick), 32'(e.ftick));
                chk("Pending",   e.t, 32'(bus.Pending), 32'(e.pending));
            end
        end
    end

    task automatic load(input logic [15:0] v, input logic [3:0] m, input logic l);
        bus.Load = 1'b1; bus.Value = v; bus.BlankMask = m; bus.LzsEn = l;
        @(negedge Clock);
        bus.Load = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic wait_phase(input int target, input int modv);
        for (int k = 0; k < 200; k++) begin
            @(negedge Clock);
            if ((model_t % modv) == target) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_phase timeout got=none want=%0d", target);
    endtask

    task automatic check_reset_pins(input string tag);
        chk({tag, "_DigitEn"},   -1, 32'(bus.DigitEn), 32'hF);
        chk({tag, "_DISPLAY"},   -1, 32'(bus.DISPLAY), 32'h7F);
        chk({tag, "_FrameTick"}, -1, 32'(bus.FrameTick), 32'h0);
        chk({tag, "_Pending"},   -1, 32'(bus.Pending), 32'h0);
    endtask

    initial begin : stimulus
        logic [31:0] v;
        logic [3:0]  m;
        bus.Load = 1'b0; bus.Value = '0; bus.BlankMask = '0; bus.LzsEn = 1'b0;
        repeat (3) @(posedge Clock);
        #1 check_reset_pins("reset");
        @(negedge Clock);
        Resetn = 1'b1;

        wait_cycles(5);
        load(16'h12AF, 4'b0000, 1'b0);
        wait_cycles(2 * FRAME);
        load(16'h0050, 4'b0000, 1'b1);
        wait_cycles(2 * FRAME);
        load(16'h0000, 4'b0000, 1'b1);
        wait_cycles(2 * FRAME);

        wait_phase(10, FRAME);
        load(16'h1111, 4'b0000, 1'b0);
        wait_cycles(3);
        load(16'h2222, 4'b0000, 1'b0);
        wait_cycles(2 * FRAME);

        wait_phase(FRAME - 1, FRAME);
        load(16'h3333, 4'b0000, 1'b0);
        wait_cycles(2 * FRAME);

        load(16'h8888, 4'b0001, 1'b0);
        wait_cycles(2 * FRAME);

        // Asynchronous reset in the middle of a lit slot.
        wait_phase(4, DIV);
        @(posedge Clock);
        #2 Resetn = 1'b0;
        sb.delete();
        #1 check_reset_pins("midreset");
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Resetn = 1'b1;
        wait_cycles(FRAME);

        for (int i = 0; i < 40; i++) begin
            if (i % 7 == 0) wait_phase(FRAME - 1, FRAME);
            else wait_cycles($urandom_range(0, 40));
            v = $urandom;
            v = v >> (4 * $urandom_range(0, 4));
            m = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            load(v[15:0], m, 1'($urandom));
        end
        wait_cycles(2 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
